// File: rtl/riscv_pkg.sv
// Shared core types: branch outcome, feedback queue entry, starvation FSM states.
// ADDR_WIDTH defaults to 32 when the build does not set it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package riscv_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    BranchOutcome      outcome;
  } fb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } starve_state_t;

  function automatic logic [1:0] min2(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fb_starve_guard.sv
// Starvation guard: counts consecutive cycles with queued feedback but no drain
// and raises fetch_hold once STARVE_LIMIT is reached.
module fb_starve_guard
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic count_nz,
  input  logic drain_nz,
  output logic fetch_hold
);

  localparam int CW = $clog2(STARVE_LIMIT) + 1;

  starve_state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc    = cnt + CW'(1);
  assign fetch_hold = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count_nz && !drain_nz) begin
            state <= WAIT;
            cnt   <= CW'(1);
          end
        end
        WAIT: begin
          if (drain_nz || !count_nz) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CW'(STARVE_LIMIT))
              state <= HOLD;
          end
        end
        HOLD: begin
          if (drain_nz || !count_nz) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/branch_fb_queue.sv
// Resolved-branch feedback queue feeding gshare only through free BRAM ports.
// Optional same-cycle bypass when empty: define BRANCH_FB_BYPASS_EN.
module branch_fb_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               res_valid,
  input  logic [ADDR_W-1:0]        res_pc [2],
  input  BranchOutcome             res_outcome [2],
  output logic                     res_ready,
  input  logic [1:0]               pred_addr_valid,
  output logic [1:0]               fb_if_branch,
  output logic [ADDR_W-1:0]        fb_branch_pc [2],
  output BranchOutcome             fb_outcome [2],
  output logic                     fetch_hold,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fb_entry_t      mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  logic [PW-1:0]  head1;
  logic [PW-1:0]  tail1;

  fb_entry_t  in0, in1, wr0, wr1, rd0, rd1;
  logic [1:0] free, n_in, n_byp, n_wr, drain;

  assign head1     = head + PW'(1);
  assign tail1     = tail + PW'(1);
  assign res_ready = (count <= CW'(DEPTH - 2));
  assign occupancy = count;
  assign rd0       = mem[head];
  assign rd1       = mem[head1];

  always_comb begin
    free = 2'd2 - {1'b0, pred_addr_valid[0]} - {1'b0, pred_addr_valid[1]};
    in1  = '{pc: res_pc[1], outcome: res_outcome[1]};
    in0  = res_valid[0] ? '{pc: res_pc[0], outcome: res_outcome[0]} : in1;
    n_in = res_ready ? ({1'b0, res_valid[0]} + {1'b0, res_valid[1]}) : 2'd0;
    if (count == '0)
      drain = 2'd0;
    else if (count == CW'(1))
      drain = min2(2'd1, free);
    else
      drain = free;
    n_byp = 2'd0;
`ifdef BRANCH_FB_BYPASS_EN
    if (count == '0 && !reset)
      n_byp = min2(n_in, free);
`endif
    n_wr = n_in - n_byp;
    wr0  = (n_byp == 2'd1) ? in1 : in0;
    wr1  = in1;

    fb_if_branch    = 2'b00;
    fb_branch_pc[0] = '0;
    fb_branch_pc[1] = '0;
    fb_outcome[0]   = NOT_TAKEN;
    fb_outcome[1]   = NOT_TAKEN;
    // Bypass only happens with an empty queue, so it never competes with storage
    if (n_byp != 2'd0) begin
      fb_if_branch[0] = 1'b1;
      fb_branch_pc[0] = in0.pc;
      fb_outcome[0]   = in0.outcome;
      if (n_byp == 2'd2) begin
        fb_if_branch[1] = 1'b1;
        fb_branch_pc[1] = in1.pc;
        fb_outcome[1]   = in1.outcome;
      end
    end else begin
      if (drain != 2'd0) begin
        fb_if_branch[0] = 1'b1;
        fb_branch_pc[0] = rd0.pc;
        fb_outcome[0]   = rd0.outcome;
      end
      if (drain == 2'd2) begin
        fb_if_branch[1] = 1'b1;
        fb_branch_pc[1] = rd1.pc;
        fb_outcome[1]   = rd1.outcome;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (n_wr != 2'd0)
        mem[tail] <= wr0;
      if (n_wr == 2'd2)
        mem[tail1] <= wr1;
      tail  <= tail + PW'(n_wr);
      head  <= head + PW'(drain);
      count <= count + CW'(n_wr) - CW'(drain);
    end
  end

  fb_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_guard (
    .clk       (clk),
    .reset     (reset),
    .count_nz  (count != '0),
    .drain_nz  (drain != 2'd0),
    .fetch_hold(fetch_hold)
  );

endmodule

// File: tb/tb_branch_fb_queue.sv
// Directed bench for branch_fb_queue: ordering, port budget, backpressure,
// wrap, starvation hold, reset flush and (when enabled) bypass.
module tb_branch_fb_queue;
  import riscv_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         res_valid = 2'b00;
  logic [ADDR_W-1:0]  res_pc [2];
  BranchOutcome       res_outcome [2];
  logic               res_ready;
  logic [1:0]         pred_addr_valid = 2'b00;
  logic [1:0]         fb_if_branch;
  logic [ADDR_W-1:0]  fb_branch_pc [2];
  BranchOutcome       fb_outcome [2];
  logic               fetch_hold;
  logic [3:0]         occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_fb_queue #(
    .DEPTH(8),
    .STARVE_LIMIT(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_outcome    (res_outcome),
    .res_ready      (res_ready),
    .pred_addr_valid(pred_addr_valid),
    .fb_if_branch   (fb_if_branch),
    .fb_branch_pc   (fb_branch_pc),
    .fb_outcome     (fb_outcome),
    .fetch_hold     (fetch_hold),
    .occupancy      (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] v,
                       input logic [31:0] p0, input BranchOutcome o0,
                       input logic [31:0] p1, input BranchOutcome o1);
    res_valid      = v;
    res_pc[0]      = ADDR_W'(p0);
    res_outcome[0] = o0;
    res_pc[1]      = ADDR_W'(p1);
    res_outcome[1] = o1;
  endtask

  initial begin
    offer(2'b00, 0, NOT_TAKEN, 0, NOT_TAKEN);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_occ", occupancy, 0);
    check("rst_ready", res_ready, 1);
    check("rst_hold", fetch_hold, 0);
    check("rst_fbv", fb_if_branch, 2'b00);
    check("rst_fbo", fb_outcome[0], NOT_TAKEN);

    // T1: two entries in, both out next cycle
    pred_addr_valid = 2'b00;
    offer(2'b11, 32'h100, TAKEN, 32'h104, NOT_TAKEN);
    #1;
`ifdef BRANCH_FB_BYPASS_EN
    check("t1_byp_v", fb_if_branch, 2'b11);
    check("t1_byp_pc0", fb_branch_pc[0], 32'h100);
    tick();
    res_valid = 2'b00;
    #1;
    check("t1_byp_occ", occupancy, 0);
`else
    check("t1_same_v", fb_if_branch, 2'b00);
    tick();
    res_valid = 2'b00;
    #1;
    check("t1_occ2", occupancy, 2);
    check("t1_v", fb_if_branch, 2'b11);
    check("t1_pc0", fb_branch_pc[0], 32'h100);
    check("t1_o0", fb_outcome[0], TAKEN);
    check("t1_pc1", fb_branch_pc[1], 32'h104);
    check("t1_o1", fb_outcome[1], NOT_TAKEN);
    tick();
    check("t1_occ0", occupancy, 0);
`endif

    // T2: three queued, one fetch read -> one drain per cycle
    pred_addr_valid = 2'b11;
    offer(2'b11, 32'h200, NOT_TAKEN, 32'h204, TAKEN);
    tick();
    offer(2'b10, 32'hDEAD, TAKEN, 32'h208, TAKEN);
    tick();
    res_valid = 2'b00;
    check("t2_occ3", occupancy, 3);
    pred_addr_valid = 2'b01;
    #1;
    check("t2_v_a", fb_if_branch, 2'b01);
    check("t2_pc_a", fb_branch_pc[0], 32'h200);
    tick();
    check("t2_occ2", occupancy, 2);
    check("t2_pc_b", fb_branch_pc[0], 32'h204);
    check("t2_o_b", fb_outcome[0], TAKEN);
    check("t2_v_b", fb_if_branch, 2'b01);
    tick();
    check("t2_pc_c", fb_branch_pc[0], 32'h208);
    check("t2_v_c", fb_if_branch, 2'b01);
    tick();
    check("t2_occ0", occupancy, 0);

    // T3: fill to 7, backpressure, then drain 2
    pred_addr_valid = 2'b11;
    offer(2'b11, 32'h300, TAKEN, 32'h304, NOT_TAKEN);
    tick();
    offer(2'b11, 32'h308, TAKEN, 32'h30C, NOT_TAKEN);
    tick();
    offer(2'b11, 32'h310, TAKEN, 32'h314, NOT_TAKEN);
    tick();
    offer(2'b01, 32'h318, TAKEN, 32'h0, NOT_TAKEN);
    tick();
    check("t3_occ7", occupancy, 7);
    check("t3_notready", res_ready, 0);
    offer(2'b11, 32'hBAD0, TAKEN, 32'hBAD4, TAKEN);
    tick();
    check("t3_ignored", occupancy, 7);
    res_valid = 2'b00;
    pred_addr_valid = 2'b00;
    #1;
    check("t3_pc0", fb_branch_pc[0], 32'h300);
    check("t3_pc1", fb_branch_pc[1], 32'h304);
    tick();
    check("t3_occ5", occupancy, 5);
    check("t3_ready", res_ready, 1);

    // T4: count 6, enqueue 2 + drain 2, pointers wrap
    pred_addr_valid = 2'b11;
    offer(2'b01, 32'h31C, NOT_TAKEN, 32'h0, NOT_TAKEN);
    tick();
    check("t4_occ6", occupancy, 6);
    check("t4_ready6", res_ready, 1);
    pred_addr_valid = 2'b00;
    offer(2'b11, 32'h400, TAKEN, 32'h404, TAKEN);
    #1;
    check("t4_pc0", fb_branch_pc[0], 32'h308);
    check("t4_pc1", fb_branch_pc[1], 32'h30C);
    tick();
    res_valid = 2'b00;
    check("t4_occ_keep", occupancy, 6);
    #1;
    check("t4_pc2", fb_branch_pc[0], 32'h310);
    check("t4_pc3", fb_branch_pc[1], 32'h314);
    tick();
    check("t4_pc4", fb_branch_pc[0], 32'h318);
    check("t4_pc5", fb_branch_pc[1], 32'h31C);
    check("t4_o5", fb_outcome[1], NOT_TAKEN);
    tick();
    check("t4_v6", fb_if_branch, 2'b11);
    check("t4_pc6", fb_branch_pc[0], 32'h400);
    check("t4_pc7", fb_branch_pc[1], 32'h404);
    tick();
    check("t4_occ0", occupancy, 0);

    // T5: starvation -> hold after 16 blocked cycles
    pred_addr_valid = 2'b11;
    offer(2'b01, 32'h500, TAKEN, 32'h0, NOT_TAKEN);
    tick();
    res_valid = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("t5_hold_%0d", i), fetch_hold, (i == 16));
    end
    check("t5_occ1", occupancy, 1);
    pred_addr_valid = 2'b00;
    #1;
    check("t5_v", fb_if_branch, 2'b01);
    check("t5_pc", fb_branch_pc[0], 32'h500);
    tick();
    check("t5_release", fetch_hold, 0);
    check("t5_occ0", occupancy, 0);

    // T6: reset with five queued flushes everything
    pred_addr_valid = 2'b11;
    offer(2'b11, 32'h700, TAKEN, 32'h704, TAKEN);
    tick();
    offer(2'b11, 32'h708, TAKEN, 32'h70C, TAKEN);
    tick();
    offer(2'b01, 32'h710, TAKEN, 32'h0, TAKEN);
    tick();
    check("t6_occ5", occupancy, 5);
    reset = 1'b1;
    offer(2'b11, 32'h720, TAKEN, 32'h724, TAKEN);
    tick();
    reset = 1'b0;
    res_valid = 2'b00;
    pred_addr_valid = 2'b00;
    #1;
    check("t6_occ0", occupancy, 0);
    check("t6_v", fb_if_branch, 2'b00);
    check("t6_ready", res_ready, 1);
    check("t6_hold", fetch_hold, 0);

`ifdef BRANCH_FB_BYPASS_EN
    offer(2'b01, 32'h600, TAKEN, 32'h0, NOT_TAKEN);
    #1;
    check("byp_v", fb_if_branch, 2'b01);
    check("byp_pc", fb_branch_pc[0], 32'h600);
    tick();
    res_valid = 2'b00;
    check("byp_occ", occupancy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
